// File: rtl/wormhole_switch_alloc_if.sv
`default_nettype none
// ============================================================================
// Module   : wormhole_switch_alloc_if
// Brief    : Flit handshake bundle between router input buffers, the switch
//            allocator and the output links (5 ports, packed per port).
// Revision : 1.0
// ============================================================================
interface wormhole_switch_alloc_if #(
    parameter int FLIT_W = 64
);
    logic [4:0]             i_in_valid;
    logic [4:0][FLIT_W-1:0] i_in_flit;
    logic [4:0]             o_in_ready;
    logic [4:0]             o_out_valid;
    logic [4:0][FLIT_W-1:0] o_out_flit;
    logic [4:0]             i_out_ready;
    logic                   o_err;

    modport master (
        output i_in_valid, i_in_flit, i_out_ready,
        input  o_in_ready, o_out_valid, o_out_flit, o_err
    );

    modport slave (
        input  i_in_valid, i_in_flit, i_out_ready,
        output o_in_ready, o_out_valid, o_out_flit, o_err
    );
endinterface
`default_nettype wire

// File: rtl/wormhole_switch_alloc.sv
`default_nettype none
// ============================================================================
// Module   : wormhole_switch_alloc
// Brief    : Registered 5-port mesh crossbar, dimension-order routing,
//            per-output round-robin arbitration and wormhole packet locking.
// Revision : 1.0
// ============================================================================
module wormhole_switch_alloc #(
    parameter int X_ADDR     = 0,
    parameter int Y_ADDR     = 0,
    parameter int ADDR_W     = 4,
    parameter int FLIT_W     = 64,
    parameter int ROUTE_MODE = 0
) (
    input  wire logic               i_clk,
    input  wire logic               i_rst,
    wormhole_switch_alloc_if.slave  bus
);
    localparam int NUM_PORTS = 5;
    localparam logic [2:0] P_LOCAL = 3'd0;
    localparam logic [2:0] P_NORTH = 3'd1;
    localparam logic [2:0] P_EAST  = 3'd2;
    localparam logic [2:0] P_SOUTH = 3'd3;
    localparam logic [2:0] P_WEST  = 3'd4;
    localparam logic [ADDR_W-1:0] C_X = ADDR_W'(X_ADDR);
    localparam logic [ADDR_W-1:0] C_Y = ADDR_W'(Y_ADDR);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

    state_t                         state_q [NUM_PORTS];
    state_t                         state_d [NUM_PORTS];
    logic [NUM_PORTS-1:0][2:0]      owner_q, owner_d;
    logic [NUM_PORTS-1:0][2:0]      ptr_q, ptr_d;
    logic [NUM_PORTS-1:0]           lock_q, lock_d;
    logic [NUM_PORTS-1:0][2:0]      lock_port_q, lock_port_d;
    logic [NUM_PORTS-1:0]           out_valid_q, out_valid_d;
    logic [NUM_PORTS-1:0][FLIT_W-1:0] out_flit_q, out_flit_d;

    logic [NUM_PORTS-1:0]           w_head, w_orphan, w_tail, w_free, w_grant, w_in_ready;
    logic [NUM_PORTS-1:0][2:0]      w_route, w_gsel;

    function automatic logic [2:0] route_of(input logic [FLIT_W-1:0] f);
        logic [ADDR_W-1:0] x, y;
        logic [2:0]        px, py;
        x  = f[ADDR_W-1:0];
        y  = f[2*ADDR_W-1:ADDR_W];
        px = (x > C_X) ? P_EAST : P_WEST;
        py = (y > C_Y) ? P_NORTH : P_SOUTH;
        if (x == C_X && y == C_Y) route_of = P_LOCAL;
        else if (ROUTE_MODE == 0) route_of = (x != C_X) ? px : py;
        else                      route_of = (y != C_Y) ? py : px;
    endfunction

    // A head arriving at an already-locked input is deliberately handled as body.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_head[i]   = bus.i_in_valid[i] &  bus.i_in_flit[i][FLIT_W-2] & ~lock_q[i];
            w_orphan[i] = bus.i_in_valid[i] & ~bus.i_in_flit[i][FLIT_W-2] & ~lock_q[i];
            w_tail[i]   = bus.i_in_flit[i][FLIT_W-1];
            w_route[i]  = route_of(bus.i_in_flit[i]);
            w_free[i]   = ~out_valid_q[i] | bus.i_out_ready[i];
        end
    end

    always_comb begin
        logic       found;
        int         idx;
        logic [2:0] g;
        found       = 1'b0;
        idx         = 0;
        g           = 3'd0;
        state_d     = state_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        lock_d      = lock_q;
        lock_port_d = lock_port_q;
        out_valid_d = out_valid_q;
        out_flit_d  = out_flit_q;
        w_grant     = '0;
        w_gsel      = '0;
        w_in_ready  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (state_q[p] == ST_IDLE) begin
                found = 1'b0;
                for (int k = 1; k <= NUM_PORTS; k++) begin
                    idx = (int'(ptr_q[p]) + k) % NUM_PORTS;
                    if (!found && w_head[idx] && w_route[idx] == 3'(p)) begin
                        found     = 1'b1;
                        w_gsel[p] = 3'(idx);
                    end
                end
                w_grant[p] = found & w_free[p];
            end else begin
                w_gsel[p]  = owner_q[p];
                w_grant[p] = w_free[p] & bus.i_in_valid[owner_q[p]] & lock_q[owner_q[p]]
                             & (lock_port_q[owner_q[p]] == 3'(p));
            end

            if (w_grant[p]) begin
                g              = w_gsel[p];
                w_in_ready[g]  = 1'b1;
                out_valid_d[p] = 1'b1;
                out_flit_d[p]  = bus.i_in_flit[g];
                if (state_q[p] == ST_IDLE) begin
                    ptr_d[p] = g;
                    if (!w_tail[g]) begin
                        state_d[p]     = ST_LOCKED;
                        owner_d[p]     = g;
                        lock_d[g]      = 1'b1;
                        lock_port_d[g] = 3'(p);
                    end
                end else if (w_tail[g]) begin
                    state_d[p] = ST_IDLE;
                    lock_d[g]  = 1'b0;
                end
            end else if (bus.i_out_ready[p]) begin
                out_valid_d[p] = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int p = 0; p < NUM_PORTS; p++) state_q[p] <= ST_IDLE;
            owner_q     <= '0;
            ptr_q       <= '0;
            lock_q      <= '0;
            lock_port_q <= '0;
            out_valid_q <= '0;
            out_flit_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            lock_q      <= lock_d;
            lock_port_q <= lock_port_d;
            out_valid_q <= out_valid_d;
            out_flit_q  <= out_flit_d;
        end
    end

    // Orphan body/tail flits are consumed and flagged rather than forwarded.
    assign bus.o_in_ready  = (w_in_ready | w_orphan) & {NUM_PORTS{~i_rst}};
    assign bus.o_err       = (|w_orphan) & ~i_rst;
    assign bus.o_out_valid = out_valid_q;
    assign bus.o_out_flit  = out_flit_q;
endmodule
`default_nettype wire

// File: tb/tb_wormhole_switch_alloc.sv
`default_nettype none
// ============================================================================
// Module   : tb_wormhole_switch_alloc
// Brief    : Directed vector table plus multi-cycle sequences for the switch.
// Revision : 1.0
// ============================================================================
module tb_wormhole_switch_alloc;
    localparam int FW = 64;
    localparam logic [1:0] TB = 2'b00, TH = 2'b01, TT = 2'b10, THT = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [4:0]         in_valid  = '0;
    logic [4:0]         out_ready = 5'b11111;
    logic [4:0][FW-1:0] in_flit   = '0;

    wormhole_switch_alloc_if #(.FLIT_W(FW)) bus0 ();
    wormhole_switch_alloc_if #(.FLIT_W(FW)) bus1 ();
    assign bus0.i_in_valid  = in_valid;
    assign bus0.i_in_flit   = in_flit;
    assign bus0.i_out_ready = out_ready;
    assign bus1.i_in_valid  = in_valid;
    assign bus1.i_in_flit   = in_flit;
    assign bus1.i_out_ready = out_ready;

    wormhole_switch_alloc #(.X_ADDR(1), .Y_ADDR(1), .ADDR_W(4), .FLIT_W(FW), .ROUTE_MODE(0))
        dut0 (.i_clk(clk), .i_rst(rst), .bus(bus0.slave));
    wormhole_switch_alloc #(.X_ADDR(1), .Y_ADDR(1), .ADDR_W(4), .FLIT_W(FW), .ROUTE_MODE(1))
        dut1 (.i_clk(clk), .i_rst(rst), .bus(bus1.slave));

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [4:0]         vld;
        logic [4:0][FW-1:0] flit;
        logic [4:0]         ordy;
        logic [4:0]         exp_ready;
        logic               exp_err;
        logic [4:0]         exp_ovalid;
        int                 chk_port;
        logic [FW-1:0]      exp_flit;
    } vec_t;
    vec_t tbl[$];

    function automatic logic [FW-1:0] mk(input logic [1:0] t, input int x, input int y, input int tag);
        logic [3:0] xs, ys;
        xs = 4'(x);
        ys = 4'(y);
        mk = {t, 54'(tag), ys, xs};
    endfunction

    task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic add(input logic [4:0] v,
                       input logic [FW-1:0] f0, input logic [FW-1:0] f1, input logic [FW-1:0] f2,
                       input logic [FW-1:0] f3, input logic [FW-1:0] f4,
                       input logic [4:0] ir, input logic e, input logic [4:0] ov,
                       input int cp, input logic [FW-1:0] ef);
        vec_t t;
        t.vld = v;
        t.flit[0] = f0; t.flit[1] = f1; t.flit[2] = f2; t.flit[3] = f3; t.flit[4] = f4;
        t.ordy = 5'b11111;
        t.exp_ready = ir; t.exp_err = e; t.exp_ovalid = ov;
        t.chk_port = cp; t.exp_flit = ef;
        tbl.push_back(t);
    endtask

    initial begin
        logic [FW-1:0] fa, fb, z;
        z = '0;

        // Reset state: valid inputs (head and orphan) are ignored while rst is high
        in_valid   = 5'b10001;
        in_flit[0] = mk(THT, 2, 1, 99);
        in_flit[4] = mk(TB, 0, 0, 98);
        #12;
        check("rst in_ready", 64'(bus0.o_in_ready), 64'(5'b0));
        check("rst err", 64'(bus0.o_err), 64'(1'b0));
        check("rst out_valid", 64'(bus0.o_out_valid), 64'(5'b0));
        check("rst out_flit2", bus0.o_out_flit[2], z);
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = '0;

        // T1: local head+tail to (2,1) goes EAST
        add(5'b00001, mk(THT,2,1,1), z, z, z, z, 5'b00001, 0, 5'b00100, 2, mk(THT,2,1,1));
        add(5'b00000, z, z, z, z, z, 5'b00000, 0, 5'b00000, -1, z);
        // T2: NORTH and SOUTH packets to (1,1); NORTH wins, no interleave
        add(5'b01010, z, mk(TH,1,1,10), z, mk(TH,1,1,20), z, 5'b00010, 0, 5'b00001, 0, mk(TH,1,1,10));
        add(5'b01010, z, mk(TB,1,1,11), z, mk(TH,1,1,20), z, 5'b00010, 0, 5'b00001, 0, mk(TB,1,1,11));
        add(5'b01010, z, mk(TT,1,1,12), z, mk(TH,1,1,20), z, 5'b00010, 0, 5'b00001, 0, mk(TT,1,1,12));
        add(5'b01000, z, z, z, mk(TH,1,1,20), z, 5'b01000, 0, 5'b00001, 0, mk(TH,1,1,20));
        add(5'b01000, z, z, z, mk(TB,1,1,21), z, 5'b01000, 0, 5'b00001, 0, mk(TB,1,1,21));
        add(5'b01000, z, z, z, mk(TT,1,1,22), z, 5'b01000, 0, 5'b00001, 0, mk(TT,1,1,22));
        add(5'b00000, z, z, z, z, z, 5'b00000, 0, 5'b00000, -1, z);
        // Three concurrent heads to WEST, SOUTH, NORTH
        add(5'b10101, mk(THT,0,1,30), z, mk(THT,1,0,31), z, mk(THT,1,2,32),
            5'b10101, 0, 5'b11010, 4, mk(THT,0,1,30));
        add(5'b00000, z, z, z, z, z, 5'b00000, 0, 5'b00000, -1, z);
        // T5: orphan body at WEST, orphan tail at NORTH
        add(5'b10000, z, z, z, z, mk(TB,0,0,40), 5'b10000, 1, 5'b00000, -1, z);
        add(5'b00010, z, mk(TT,0,0,41), z, z, z, 5'b00010, 1, 5'b00000, -1, z);
        // Round robin on LOCAL output (ptr=3 after SOUTH): WEST, then NORTH, then EAST
        add(5'b10110, z, mk(THT,1,1,50), mk(THT,1,1,51), z, mk(THT,1,1,52),
            5'b10000, 0, 5'b00001, 0, mk(THT,1,1,52));
        add(5'b00110, z, mk(THT,1,1,50), mk(THT,1,1,51), z, z, 5'b00010, 0, 5'b00001, 0, mk(THT,1,1,50));
        add(5'b00100, z, z, mk(THT,1,1,51), z, z, 5'b00100, 0, 5'b00001, 0, mk(THT,1,1,51));
        add(5'b00000, z, z, z, z, z, 5'b00000, 0, 5'b00000, -1, z);

        for (int k = 0; k < tbl.size(); k++) begin
            in_valid  = tbl[k].vld;
            in_flit   = tbl[k].flit;
            out_ready = tbl[k].ordy;
            @(negedge clk);
            check($sformatf("v%0d in_ready", k), 64'(bus0.o_in_ready), 64'(tbl[k].exp_ready));
            check($sformatf("v%0d err", k), 64'(bus0.o_err), 64'(tbl[k].exp_err));
            @(posedge clk); #1;
            check($sformatf("v%0d out_valid", k), 64'(bus0.o_out_valid), 64'(tbl[k].exp_ovalid));
            if (tbl[k].chk_port >= 0)
                check($sformatf("v%0d out_flit", k), bus0.o_out_flit[tbl[k].chk_port], tbl[k].exp_flit);
        end

        // T3: EAST stalls for four cycles with a second flit queued behind
        fa = mk(THT, 2, 1, 70);
        fb = mk(THT, 2, 1, 71);
        in_valid = 5'b00001;
        in_flit[0] = fa;
        @(negedge clk);
        check("t3 grant a", 64'(bus0.o_in_ready[0]), 64'(1'b1));
        @(posedge clk); #1;
        out_ready[2] = 1'b0;
        in_flit[0] = fb;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check($sformatf("t3 c%0d valid", c), 64'(bus0.o_out_valid[2]), 64'(1'b1));
            check($sformatf("t3 c%0d flit", c), bus0.o_out_flit[2], fa);
            check($sformatf("t3 c%0d ready", c), 64'(bus0.o_in_ready[0]), 64'(1'b0));
            @(posedge clk); #1;
        end
        out_ready[2] = 1'b1;
        @(negedge clk);
        check("t3 grant b", 64'(bus0.o_in_ready[0]), 64'(1'b1));
        @(posedge clk); #1;
        in_valid = '0;
        check("t3 b valid", 64'(bus0.o_out_valid), 64'(5'b00100));
        check("t3 b flit", bus0.o_out_flit[2], fb);
        @(posedge clk); #1;
        check("t3 drained", 64'(bus0.o_out_valid), 64'(5'b0));

        // T4: dest (2,2) goes EAST in XY mode and NORTH in YX mode
        in_valid = 5'b00001;
        in_flit[0] = mk(THT, 2, 2, 80);
        @(negedge clk);
        check("t4 xy ready", 64'(bus0.o_in_ready), 64'(5'b00001));
        check("t4 yx ready", 64'(bus1.o_in_ready), 64'(5'b00001));
        @(posedge clk); #1;
        in_valid = '0;
        check("t4 xy valid", 64'(bus0.o_out_valid), 64'(5'b00100));
        check("t4 yx valid", 64'(bus1.o_out_valid), 64'(5'b00010));
        check("t4 yx flit", bus1.o_out_flit[1], mk(THT, 2, 2, 80));
        @(posedge clk); #1;

        // T6: reset in the middle of a 4-flit packet
        in_valid = 5'b00001;
        in_flit[0] = mk(TH, 2, 1, 90);
        @(posedge clk); #1;
        in_flit[0] = mk(TB, 2, 1, 91);
        @(posedge clk); #1;
        check("t6 body out", bus0.o_out_flit[2], mk(TB, 2, 1, 91));
        #2 rst = 1'b1;
        #1;
        check("t6 async valid", 64'(bus0.o_out_valid), 64'(5'b0));
        check("t6 async ready", 64'(bus0.o_in_ready), 64'(5'b0));
        check("t6 async flit", bus0.o_out_flit[2], z);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        in_flit[0] = mk(THT, 1, 2, 92);
        #1;
        check("t6 new head ready", 64'(bus0.o_in_ready), 64'(5'b00001));
        @(posedge clk); #1;
        check("t6 new head valid", 64'(bus0.o_out_valid), 64'(5'b00010));
        check("t6 new head flit", bus0.o_out_flit[1], mk(THT, 1, 2, 92));
        in_flit[0] = mk(TB, 2, 1, 93);
        @(negedge clk);
        check("t6 lock dropped err", 64'(bus0.o_err), 64'(1'b1));
        @(posedge clk); #1;
        in_valid = '0;
        check("t6 no output", 64'(bus0.o_out_valid), 64'(5'b0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
`default_nettype wire
